md_unit_ctrl: RTL



---
 rtl/md_unit_ctrl_pkg.sv | 29 ++
 rtl/md_arith.sv | 57 +++++
 rtl/md_unit_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - md op encodings as presented on the EX-stage op bus
//   - FSM state encodings for the controller
//   - default busy-window lengths
//   - is_long_op(): true for the ops that occupy the unit for a busy window
// -----------------------------------------------------------------------------
package md_unit_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // mult/multu/div/divu are the multi-cycle ops; mthi/mtlo and reserved are not.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Combinational 64-bit result generator for the md unit.
// Ports:
//   i_op            md op code (only mult/multu/div/divu produce a result)
//   i_a, i_b        32-bit operands (rs, rt)
//   o_result        {hi, lo}: product, or {remainder, quotient}
//   o_div_by_zero   divide op with i_b == 0; o_result is then don't-care (0)
// -----------------------------------------------------------------------------
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic w_b_zero;
  logic w_sdiv_ovf;

  assign w_b_zero   = (i_b == 32'h0);
  // The single signed quotient that does not fit in 32 bits; pinned explicitly
  // so the result never depends on how the simulator/synth handles overflow.
  assign w_sdiv_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves
    // a value unassigned, which would otherwise infer a latch.
    o_result      = 64'h0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MD_MULT:  o_result = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
      MD_MULTU: o_result = {32'h0, i_a} * {32'h0, i_b};
      MD_DIV: begin
        if (w_b_zero) begin
          o_div_by_zero = 1'b1;
        end else if (w_sdiv_ovf) begin
          o_result = {32'h0, 32'h8000_0000};
        end else begin
          // Signed / truncates toward zero; % takes the sign of the dividend.
          o_result = {$signed(i_a) % $signed(i_b), $signed(i_a) / $signed(i_b)};
        end
      end
      MD_DIVU: begin
        if (w_b_zero) begin
          o_div_by_zero = 1'b1;
        end else begin
          o_result = {i_a % i_b, i_a / i_b};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl
// HI/LO multiply/divide sequencer in EX. Accepts an md op from IDLE, holds the
// unit busy for a fixed number of cycles, then commits the result to HI/LO.
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   start        EX holds an md instruction this cycle
//   op           0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   A, B         forwarded rs / rt operands, sampled only on the accepting edge
//   md_use_d     ID holds an md-type instruction (incl. mfhi/mflo)
//   busy         multi-cycle op in flight
//   hi, lo       architectural HI / LO
//   stall_md     hold the ID-stage md instruction (combinational)
// -----------------------------------------------------------------------------
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_pend;
  logic          r_pend_dz;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic [63:0]   w_result;
  logic          w_dz;
  logic          w_is_mult;

  md_arith u_arith (
    .i_op          (op),
    .i_a           (A),
    .i_b           (B),
    .o_result      (w_result),
    .o_div_by_zero (w_dz)
  );

  assign w_is_mult = (op == MD_MULT) || (op == MD_MULTU);

  always_ff @(posedge clk) begin
    // NOTE: the pending result regs are reset along with HI/LO even though they
    // are always written before use; this keeps post-reset state fully defined.
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_dz <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        // NOTE: non-blocking assignments everywhere here so every register
        // samples pre-edge values, independent of statement order.
        if (is_long_op(op)) begin
          r_pend    <= w_result;
          r_pend_dz <= w_dz;
          r_cnt     <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          r_state   <= ST_BUSY;
        end else if (op == MD_MTHI) begin
          r_hi <= A;
        end else if (op == MD_MTLO) begin
          r_lo <= A;
        end
      end
    end else begin
      // BUSY: any start is ignored, including on the final (counter==1) cycle.
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        if (!r_pend_dz) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
        r_state <= ST_IDLE;
      end
    end
  end

  assign busy     = (r_state == ST_BUSY);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall_md = md_use_d & (busy | (start & is_long_op(op)));

endmodule
